// File: rtl/bp_nonsynth_commit_matcher.sv
// Commit/writeback matcher for cosimulation and tracing.
// Commit records arrive in order and may never be stalled. Register writebacks
// arrive later, in any order. Every commit is paired with the data written to
// its destination register. One complete record per instruction leaves on a
// valid/ready stream. Overflow and writeback-timeout conditions are latched as
// a sticky error.
module bp_nonsynth_commit_matcher #(
    parameter int vaddr_width_p = 39,
    parameter int data_width_p  = 64,
    parameter int rf_num_p      = 2,
    parameter int commit_els_p  = 16,
    parameter int wb_els_p      = 4,
    parameter int timeout_p     = 1024,
    localparam int rf_w_lp      = (rf_num_p > 1) ? $clog2(rf_num_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             commit_v_i,
    input  logic                             commit_debug_i,
    input  logic                             commit_trap_i,
    input  logic [vaddr_width_p-1:0]         commit_pc_i,
    input  logic [31:0]                      commit_instr_i,
    input  logic [63:0]                      commit_cause_i,
    input  logic [rf_num_p-1:0]              commit_rf_i,
    output logic                             commit_ready_o,
    input  logic [rf_num_p-1:0]              wb_v_i,
    input  logic [rf_num_p*5-1:0]            wb_addr_i,
    input  logic [rf_num_p*data_width_p-1:0] wb_data_i,
    output logic                             out_v_o,
    input  logic                             out_ready_i,
    output logic                             out_debug_o,
    output logic                             out_trap_o,
    output logic                             out_wb_v_o,
    output logic [vaddr_width_p-1:0]         out_pc_o,
    output logic [31:0]                      out_instr_o,
    output logic [63:0]                      out_cause_o,
    output logic [rf_w_lp-1:0]               out_rf_o,
    output logic [data_width_p-1:0]          out_data_o,
    output logic [31:0]                      out_count_o,
    output logic                             err_o,
    output logic [1:0]                       err_code_o
);
    localparam int cq_aw_lp = $clog2(commit_els_p);
    localparam int wb_aw_lp = $clog2(wb_els_p);
    // A writeback FIFO is addressed by {channel, register}.
    localparam int fw_lp    = rf_w_lp + 5;
    localparam int nf_lp    = 1 << fw_lp;

    // Commit queue storage. The channel and the needs-writeback flag are
    // decoded once, when the record is pushed.
    logic [vaddr_width_p-1:0] r_cq_pc     [commit_els_p];
    logic [31:0]              r_cq_instr  [commit_els_p];
    logic [63:0]              r_cq_cause  [commit_els_p];
    logic                     r_cq_debug  [commit_els_p];
    logic                     r_cq_trap   [commit_els_p];
    logic                     r_cq_needwb [commit_els_p];
    logic [rf_w_lp-1:0]       r_cq_chan   [commit_els_p];
    logic [cq_aw_lp:0]        r_cq_wptr, r_cq_rptr;

    logic [data_width_p-1:0]  r_wb_mem  [nf_lp][wb_els_p];
    logic [wb_aw_lp:0]        r_wb_wptr [nf_lp];
    logic [wb_aw_lp:0]        r_wb_rptr [nf_lp];

    logic                     r_out_v, r_out_debug, r_out_trap, r_out_wb_v;
    logic [vaddr_width_p-1:0] r_out_pc;
    logic [31:0]              r_out_instr, r_out_count, r_wait;
    logic [63:0]              r_out_cause;
    logic [rf_w_lp-1:0]       r_out_rf;
    logic [data_width_p-1:0]  r_out_data;
    logic                     r_err;
    logic [1:0]               r_err_code;

    logic                     w_cq_empty, w_cq_full, w_cq_push, w_cq_pop;
    logic [cq_aw_lp-1:0]      w_cq_ridx;
    logic [rf_w_lp-1:0]       w_in_chan, w_hd_chan;
    logic                     w_in_needwb, w_hd_needwb, w_hd_v, w_hd_debug, w_hd_trap;
    logic [vaddr_width_p-1:0] w_hd_pc;
    logic [31:0]              w_hd_instr;
    logic [63:0]              w_hd_cause;
    logic [fw_lp-1:0]         w_hd_fidx;
    logic                     w_hd_avail, w_hd_ready, w_blocked, w_load, w_wb_pop;
    logic [data_width_p-1:0]  w_hd_data;
    logic [fw_lp-1:0]         w_wb_fidx [rf_num_p];
    logic [rf_num_p-1:0]      w_wb_keep, w_wb_full, w_wb_push, w_wb_drop;
    logic                     w_err_cq, w_err_wb, w_err_to;
    logic [1:0]               w_err_code;

    // The lowest set bit wins when an instruction names several channels.
    function automatic logic [rf_w_lp-1:0] f_chan_sel(input logic [rf_num_p-1:0] rf);
        logic [rf_w_lp-1:0] sel;
        sel = '0;
        for (int i = rf_num_p - 1; i >= 0; i--)
            if (rf[i]) sel = rf_w_lp'(i);
        return sel;
    endfunction

    assign w_in_chan   = f_chan_sel(commit_rf_i);
    assign w_in_needwb = (|commit_rf_i) && !(w_in_chan == '0 && commit_instr_i[11:7] == 5'd0);
    assign w_cq_empty  = (r_cq_wptr == r_cq_rptr);
    assign w_cq_full   = (r_cq_wptr[cq_aw_lp] != r_cq_rptr[cq_aw_lp]) &&
                         (r_cq_wptr[cq_aw_lp-1:0] == r_cq_rptr[cq_aw_lp-1:0]);
    assign w_cq_ridx   = r_cq_rptr[cq_aw_lp-1:0];

    // Select the head record. An empty queue lets the incoming commit through
    // so that it can be loaded in the same cycle.
    always_comb begin
        w_hd_pc     = r_cq_pc[w_cq_ridx];
        w_hd_instr  = r_cq_instr[w_cq_ridx];
        w_hd_cause  = r_cq_cause[w_cq_ridx];
        w_hd_debug  = r_cq_debug[w_cq_ridx];
        w_hd_trap   = r_cq_trap[w_cq_ridx];
        w_hd_needwb = r_cq_needwb[w_cq_ridx];
        w_hd_chan   = r_cq_chan[w_cq_ridx];
        if (w_cq_empty) begin
            w_hd_pc     = commit_pc_i;
            w_hd_instr  = commit_instr_i;
            w_hd_cause  = commit_cause_i;
            w_hd_debug  = commit_debug_i;
            w_hd_trap   = commit_trap_i;
            w_hd_needwb = w_in_needwb;
            w_hd_chan   = w_in_chan;
        end
    end

    assign w_hd_v     = commit_v_i || !w_cq_empty;
    assign w_hd_fidx  = {w_hd_chan, w_hd_instr[11:7]};
    assign w_hd_avail = (r_wb_wptr[w_hd_fidx] != r_wb_rptr[w_hd_fidx]);
    assign w_hd_data  = r_wb_mem[w_hd_fidx][r_wb_rptr[w_hd_fidx][wb_aw_lp-1:0]];
    assign w_hd_ready = w_hd_v && (!w_hd_needwb || w_hd_avail);
    assign w_blocked  = w_hd_v && w_hd_needwb && !w_hd_avail;
    assign w_load     = w_hd_ready && (!r_out_v || out_ready_i);
    assign w_wb_pop   = w_load && w_hd_needwb;
    assign w_cq_pop   = w_load && !w_cq_empty;
    assign w_cq_push  = commit_v_i && !(w_cq_empty && w_load) && (!w_cq_full || w_cq_pop);
    assign w_err_cq   = commit_v_i && w_cq_full && !w_cq_pop;

    // Writeback acceptance per channel. A pop of the same FIFO in this cycle
    // frees the slot for the push.
    always_comb begin
        w_wb_keep = '0;
        w_wb_full = '0;
        w_wb_push = '0;
        w_wb_drop = '0;
        for (int c = 0; c < rf_num_p; c++) begin
            w_wb_fidx[c] = {rf_w_lp'(c), wb_addr_i[c*5 +: 5]};
            w_wb_keep[c] = wb_v_i[c] && !(c == 0 && wb_addr_i[c*5 +: 5] == 5'd0);
            w_wb_full[c] = ((r_wb_wptr[w_wb_fidx[c]] ^ r_wb_rptr[w_wb_fidx[c]]) ==
                            {1'b1, {wb_aw_lp{1'b0}}});
            w_wb_push[c] = w_wb_keep[c] &&
                           (!w_wb_full[c] || (w_wb_pop && (w_hd_fidx == w_wb_fidx[c])));
            w_wb_drop[c] = w_wb_keep[c] && !w_wb_push[c];
        end
    end

    assign w_err_wb   = |w_wb_drop;
    assign w_err_to   = w_blocked && (r_wait == 32'(timeout_p - 1));
    assign w_err_code = w_err_cq ? 2'd1 : (w_err_wb ? 2'd2 : (w_err_to ? 2'd3 : 2'd0));

    // Commit queue payload writes. Only the pointers need a reset.
    always_ff @(posedge clk_i) begin
        if (w_cq_push) begin
            r_cq_pc[r_cq_wptr[cq_aw_lp-1:0]]     <= commit_pc_i;
            r_cq_instr[r_cq_wptr[cq_aw_lp-1:0]]  <= commit_instr_i;
            r_cq_cause[r_cq_wptr[cq_aw_lp-1:0]]  <= commit_cause_i;
            r_cq_debug[r_cq_wptr[cq_aw_lp-1:0]]  <= commit_debug_i;
            r_cq_trap[r_cq_wptr[cq_aw_lp-1:0]]   <= commit_trap_i;
            r_cq_needwb[r_cq_wptr[cq_aw_lp-1:0]] <= w_in_needwb;
            r_cq_chan[r_cq_wptr[cq_aw_lp-1:0]]   <= w_in_chan;
        end
    end

    // Writeback FIFO payload writes.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < rf_num_p; c++)
            if (w_wb_push[c])
                r_wb_mem[w_wb_fidx[c]][r_wb_wptr[w_wb_fidx[c]][wb_aw_lp-1:0]] <=
                    wb_data_i[c*data_width_p +: data_width_p];
    end

    // Writeback FIFO pointers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int f = 0; f < nf_lp; f++) begin
                r_wb_wptr[f] <= '0;
                r_wb_rptr[f] <= '0;
            end
        end else begin
            for (int c = 0; c < rf_num_p; c++)
                if (w_wb_push[c])
                    r_wb_wptr[w_wb_fidx[c]] <= r_wb_wptr[w_wb_fidx[c]] + (wb_aw_lp+1)'(1);
            if (w_wb_pop)
                r_wb_rptr[w_hd_fidx] <= r_wb_rptr[w_hd_fidx] + (wb_aw_lp+1)'(1);
        end
    end

    // Queue pointers, the wait counter and the sticky error.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cq_wptr  <= '0;
            r_cq_rptr  <= '0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            if (w_cq_push) r_cq_wptr <= r_cq_wptr + (cq_aw_lp+1)'(1);
            if (w_cq_pop)  r_cq_rptr <= r_cq_rptr + (cq_aw_lp+1)'(1);
            if (w_load)         r_wait <= '0;
            else if (w_blocked) r_wait <= r_wait + 32'd1;
            if (!r_err && (w_err_code != 2'd0)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    // Output record register. It holds steady while the consumer stalls, and
    // the retire count travels with the record.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_out_v     <= 1'b0;
            r_out_debug <= 1'b0;
            r_out_trap  <= 1'b0;
            r_out_wb_v  <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_out_cause <= '0;
            r_out_rf    <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_load) begin
            r_out_v     <= 1'b1;
            r_out_debug <= w_hd_debug;
            r_out_trap  <= w_hd_trap;
            r_out_wb_v  <= w_hd_needwb;
            r_out_pc    <= w_hd_pc;
            r_out_instr <= w_hd_instr;
            r_out_cause <= w_hd_cause;
            r_out_rf    <= w_hd_chan;
            r_out_data  <= w_hd_needwb ? w_hd_data : '0;
            r_out_count <= r_out_count + {31'd0, !(w_hd_trap || w_hd_debug)};
        end else if (out_ready_i) begin
            r_out_v <= 1'b0;
        end
    end

    assign commit_ready_o = !w_cq_full;
    assign out_v_o        = r_out_v;
    assign out_debug_o    = r_out_debug;
    assign out_trap_o     = r_out_trap;
    assign out_wb_v_o     = r_out_wb_v;
    assign out_pc_o       = r_out_pc;
    assign out_instr_o    = r_out_instr;
    assign out_cause_o    = r_out_cause;
    assign out_rf_o       = r_out_rf;
    assign out_data_o     = r_out_data;
    assign out_count_o    = r_out_count;
    assign err_o          = r_err;
    assign err_code_o     = r_err_code;
endmodule
